// File: rtl/dma_ahb_master.sv
`default_nettype none
// ============================================================================
//  Module      : dma_ahb_master
//  Description : AHB-Lite master port of the DMA engine. Accepts one rd/wr
//                command pulse at a time, runs one SINGLE 32-bit NONSEQ
//                transfer, and returns a one-cycle rd_en (with rdata) or
//                wr_ack pulse. Keeps sticky error status and the address of
//                the first bus error / timeout.
//  Ports       : clk, rst (sync, active-high)
//                rd, wr, addr, wdata          - command side
//                rdata, rd_en, wr_ack, busy   - completion side
//                err_status, err_addr, err_clr- error status for register block
//                haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
//                hrdata, hready, hresp        - AHB-Lite master
//  Config      : define DMA_AHB_TIMEOUT_EN to enable the wait-state timeout
//                (TIMEOUT_CYC cycles, TO_W-bit counter). Undefined: the block
//                waits indefinitely and err_status[3] stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_ahb_master #(
    parameter int TIMEOUT_CYC = 256,
    parameter int TO_W        = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rd_en,
    output logic        wr_ack,
    output logic        busy,
    output logic [3:0]  err_status,
    output logic [31:0] err_addr,
    input  logic        err_clr,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_addr = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;

    // The counter must be able to represent TIMEOUT_CYC.
    generate
        if ((1 << TO_W) <= TIMEOUT_CYC) begin : g_param_check
            $error("dma_ahb_master: TO_W too small for TIMEOUT_CYC");
        end
    endgenerate

    logic [1:0]  r_state;
    logic [31:0] r_cmd_addr;
    logic [31:0] r_cmd_wdata;
    logic        r_cmd_wr;

    logic        w_capture;
    logic        w_collision;
    logic        w_overrun;
    logic        w_bus_err;
    logic        w_timeout;
    logic        w_xfer_done;
    logic        w_err_addr_ld;
    logic [3:0]  w_err_set;

    assign w_capture   = (rd || wr) && (r_state == c_st_idle);
    assign w_collision = rd && wr && (r_state == c_st_idle);
    assign w_overrun   = (rd || wr) && (r_state != c_st_idle);
    assign w_bus_err   = (r_state == c_st_data) && hready && hresp;

`ifdef DMA_AHB_TIMEOUT_EN
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_waiting;

    assign w_waiting = ((r_state == c_st_addr) || (r_state == c_st_data)) && !hready;
    // Fires on the edge that would bring the count to TIMEOUT_CYC, so DONE is
    // entered exactly TIMEOUT_CYC stalled cycles after entering ADDR.
    assign w_timeout = w_waiting && (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (rst || w_capture) begin
            r_to_cnt <= '0;
        end else if (w_waiting) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_xfer_done = ((r_state == c_st_data) && hready) || w_timeout;

    assign hsize  = 3'b010;
    assign hburst = 3'b000;
    assign hprot  = 4'b0011;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_wr    <= 1'b0;
            htrans      <= c_htrans_idle;
            haddr       <= '0;
            hwrite      <= 1'b0;
            hwdata      <= '0;
            rdata       <= '0;
            rd_en       <= 1'b0;
            wr_ack      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rd_en  <= 1'b0;
            wr_ack <= 1'b0;
            if (w_xfer_done) begin
                // Normal completion, ERROR completion and timeout all issue
                // the done pulse so the channel controller never stalls.
                r_state <= c_st_done;
                htrans  <= c_htrans_idle;
                rd_en   <= !r_cmd_wr;
                wr_ack  <= r_cmd_wr;
                if (!r_cmd_wr) begin
                    rdata <= (w_bus_err || w_timeout) ? '0 : hrdata;
                end
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (w_capture) begin
                            // On a collision the read wins.
                            r_state     <= c_st_addr;
                            busy        <= 1'b1;
                            r_cmd_addr  <= addr;
                            r_cmd_wdata <= wdata;
                            r_cmd_wr    <= !rd;
                            htrans      <= c_htrans_nonseq;
                            haddr       <= {addr[31:2], 2'b00};
                            hwrite      <= !rd;
                        end
                    end
                    c_st_addr: begin
                        if (hready) begin
                            r_state <= c_st_data;
                            htrans  <= c_htrans_idle;
                            if (r_cmd_wr) begin
                                hwdata <= r_cmd_wdata;
                            end
                        end
                    end
                    c_st_done: begin
                        busy    <= 1'b0;
                        r_state <= c_st_idle;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // A new error event outranks a simultaneous clear.
    assign w_err_set     = {w_timeout, w_collision, w_overrun, w_bus_err};
    assign w_err_addr_ld = (w_bus_err || w_timeout) &&
                           (err_clr || !(err_status[0] || err_status[3]));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_status <= '0;
            err_addr   <= '0;
        end else begin
            err_status <= (err_clr ? 4'b0000 : err_status) | w_err_set;
            if (w_err_addr_ld) begin
                err_addr <= r_cmd_addr;
            end else if (err_clr) begin
                err_addr <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_ahb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_ahb_master
//  Description : Self-checking bench for dma_ahb_master. Stimulus pushes the
//                expected completion of each command into a scoreboard queue;
//                a negedge monitor checks AHB address/data phases and pops the
//                queue on every done pulse. Expected latency and error flags
//                come from a transaction-level model (cycle arithmetic).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_ahb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0, err_clr = 1'b0;
    logic [31:0] addr = '0, wdata = '0, hrdata = '0;
    logic        hready = 1'b1, hresp = 1'b0;
    logic [31:0] rdata, err_addr, haddr, hwdata;
    logic        rd_en, wr_ack, busy, hwrite;
    logic [3:0]  err_status, hprot;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;

    dma_ahb_master #(.TIMEOUT_CYC(8), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rd_en(rd_en), .wr_ack(wr_ack), .busy(busy),
        .err_status(err_status), .err_addr(err_addr), .err_clr(err_clr),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_rd;
        logic [31:0] haddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
        int          n_ns;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  exp_err      = '0;
    logic [31:0] exp_err_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int n_ns    = 0;
    bit in_data = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            n_ns    = 0;
            in_data = 1'b0;
        end else begin
            if (in_data) begin
                chk("htrans_data_phase", 32'(htrans), 32'd0);
                if (sb.size() > 0 && !sb[0].is_rd) chk("hwdata", hwdata, sb[0].wdata);
                if (hready) in_data = 1'b0;
            end
            if (htrans == 2'b10) begin
                n_ns++;
                if (sb.size() > 0) begin
                    chk("haddr", haddr, sb[0].haddr);
                    chk("hwrite", 32'(hwrite), 32'(!sb[0].is_rd));
                end
                if (hready) in_data = 1'b1;
            end
            if (rd_en || wr_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse rd_en=%0b wr_ack=%0b expected none (cycle %0d)",
                             rd_en, wr_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_rd_en", 32'(rd_en), 32'(e.is_rd));
                    chk("pulse_wr_ack", 32'(wr_ack), 32'(!e.is_rd));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("nonseq_cycles", 32'(n_ns), 32'(e.n_ns));
                    if (e.is_rd) chk("rdata", rdata, e.rdata);
                end
                n_ns    = 0;
                in_data = 1'b0;
            end
        end
    end

    // ---------------- model helpers ----------------
    task automatic note_fault(input logic [31:0] a, input int bitn);
        if (!(exp_err[0] || exp_err[3])) exp_err_addr = a;
        exp_err[bitn] = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err_status"}, 32'(err_status), 32'(exp_err));
        chk({tag, "_err_addr"}, err_addr, exp_err_addr);
    endtask

    task automatic do_clear();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr      = 1'b0;
        exp_err      = '0;
        exp_err_addr = '0;
        chk("err_clr_status", 32'(err_status), 32'd0);
        chk("err_clr_addr", err_addr, 32'd0);
    endtask

    // One command; wa/wdc = hready-low cycles in the address/data phase,
    // ovr_at = cycle offset (1 = first ADDR cycle) of an extra pulse, 0 = none.
    task automatic run_xfer(input bit is_rd, input bit collide, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdv,
                            input int wa, input int wdc, input bit berr,
                            input int ovr_at, input bit ovr_wr);
        exp_t e;
        bit   eff_rd = is_rd || collide;
        e.is_rd = eff_rd;
        e.haddr = a & 32'hFFFF_FFFC;
        e.wdata = wd;
        e.rdata = berr ? 32'd0 : rdv;
        e.cyc   = cyc + 3 + wa + wdc;
        e.n_ns  = wa + 1;
        sb.push_back(e);
        if (collide) exp_err[2] = 1'b1;
        if (berr) note_fault(a, 0);
        if (ovr_at > 0) exp_err[1] = 1'b1;

        rd = eff_rd; wr = collide || !is_rd; addr = a; wdata = wd;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom;
        chk("busy_cycle1", 32'(busy), 32'd1);
        for (int k = 1; k <= wa + wdc + 3; k++) begin
            if (k == ovr_at) begin
                rd = !ovr_wr; wr = ovr_wr;
            end else begin
                rd = 1'b0; wr = 1'b0;
            end
            if (k <= wa + 1) begin
                hready = (k == wa + 1); hresp = 1'b0; hrdata = $urandom;
            end else if (k <= wa + wdc + 2) begin
                hready = ((k - wa - 2) == wdc);
                hresp  = berr && ((k - wa - 2) >= wdc - 1);
                hrdata = hready ? rdv : $urandom;
            end else begin
                hready = 1'($urandom); hresp = 1'b0; hrdata = $urandom;
            end
            @(posedge clk); #1;
        end
        rd = 1'b0; wr = 1'b0; hready = 1'b1; hresp = 1'b0;
        check_idle("post_xfer");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit is_rd, collide, berr, ow;
        int wa, wdc, ovr;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_pulses", {29'd0, hwrite, rd_en, wr_ack}, 32'd0);
        check_idle("rst");
        chk("const_hsize_hburst_hprot", {22'd0, hsize, hburst, hprot}, {22'd0, 3'b010, 3'b000, 4'b0011});

        // Directed scenarios
        run_xfer(1, 0, 32'h2000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        run_xfer(0, 0, 32'h4000_0010, 32'h1234_5678, 32'h0, 0, 2, 0, 0, 0);
        run_xfer(1, 0, 32'h2000_0004, 32'h0, 32'hCAFE_F00D, 0, 1, 1, 0, 0);
        chk("berr_status", 32'(err_status), 32'h1);
        do_clear();
        run_xfer(0, 1, 32'h3000_0008, 32'h5555_AAAA, 32'h0BAD_F00D, 0, 0, 0, 1, 0);
        chk("collide_overrun_status", 32'(err_status), 32'h6);
        do_clear();

        // Randomized traffic, back-to-back and with misaligned addresses
        for (int n = 0; n < 40; n++) begin
            is_rd   = 1'($urandom);
            collide = ($urandom_range(0, 7) == 0);
            berr    = ($urandom_range(0, 4) == 0);
            wa      = $urandom_range(0, 3);
            wdc     = berr ? $urandom_range(1, 3) : $urandom_range(0, 3);
            ovr     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, wa + wdc + 3) : 0;
            ow      = 1'($urandom);
            run_xfer(is_rd, collide, $urandom, $urandom, $urandom, wa, wdc, berr, ovr, ow);
            if ($urandom_range(0, 3) == 0) do_clear();
        end

`ifdef DMA_AHB_TIMEOUT_EN
        begin
            exp_t e;
            e.is_rd = 1'b1; e.haddr = 32'h5000_0020; e.wdata = '0; e.rdata = '0;
            e.cyc = cyc + 9; e.n_ns = 8;
            sb.push_back(e);
            note_fault(32'h5000_0020, 3);
            rd = 1'b1; addr = 32'h5000_0020; hready = 1'b0;
            @(posedge clk); #1;
            rd = 1'b0;
            repeat (9) @(posedge clk);
            #1;
            hready = 1'b1;
            check_idle("timeout");
            do_clear();
        end
`endif

        // Reset in the middle of a stalled read: no pulse, all outputs reset
        rd = 1'b1; addr = 32'h6000_0040; hready = 1'b0;
        @(posedge clk); #1;
        rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        chk("midrst_overrun_flag", 32'(err_status[1]), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_htrans", 32'(htrans), 32'd0);
        chk("midrst_haddr", haddr, 32'd0);
        chk("midrst_outputs", {29'd0, hwrite, rd_en, wr_ack}, 32'd0);
        chk("midrst_rdata_hwdata", rdata | hwdata, 32'd0);
        exp_err = '0; exp_err_addr = '0;
        check_idle("midrst");
        hready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_xfer(1, 0, 32'h7000_0003, 32'h0, 32'h1357_9BDF, 1, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
